// File: rtl/frame_mem_loader.sv
// Purpose     : assembles a host byte stream into a DATA_DEPTH x 16 frame memory and serves the gpu read port.
// Latency     : data_input is valid 1 cycle after input_addr; a word is written on the cycle its high byte is accepted.
// Backpressure: rx_ready is low only in the single DONE cycle at the end of each load.
// Ports: clk, rst (synchronous, active-high); rx_data/rx_valid/rx_ready host byte stream;
//        input_addr/data_input gpu read port; load_busy, load_done, load_err, word_cnt load status.
// Option: define FRAME_CHECKSUM_EN to expect a 16-bit sum trailer after the data words.
module frame_mem_loader #(
    parameter int DATA_DEPTH = 1024,
    parameter int ADDR_W     = 20,
    parameter int WORD_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic [ADDR_W-1:0] input_addr,
    output logic [WORD_W-1:0] data_input,
    output logic              load_busy,
    output logic              load_done,
    output logic              load_err,
    output logic [10:0]       word_cnt
);
    localparam int                MEM_AW  = $clog2(DATA_DEPTH);
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DATA_DEPTH);
    localparam logic [10:0]       DEPTH_C = 11'(DATA_DEPTH);
    localparam logic [15:0]       DEPTH_N = 16'(DATA_DEPTH);

    typedef enum logic [2:0] {
        IDLE, LEN_HI, DATA_LO, DATA_HI, CS_LO, CS_HI, DONE
    } state_t;

    // State entered once the length or the last data word has been taken.
`ifdef FRAME_CHECKSUM_EN
    localparam state_t END_ST = CS_LO;
`else
    localparam state_t END_ST = DONE;
`endif

    state_t            state_q, state_d;
    logic [7:0]        lo_q, lo_d;          // pending low byte (length, data or trailer)
    logic [15:0]       rem_q, rem_d;        // data words still to be consumed
    logic [10:0]       word_cnt_q, word_cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [WORD_W-1:0] data_input_q;
`ifdef FRAME_CHECKSUM_EN
    logic [15:0]       csum_q, csum_d;
`endif

    logic [WORD_W-1:0] mem [DATA_DEPTH];
    logic              mem_we;
    logic [MEM_AW-1:0] mem_wa;
    logic [15:0]       rx_word;
    logic              accept;

    assign rx_ready = (state_q != DONE);
    assign accept   = rx_valid & rx_ready;
    assign rx_word  = {rx_data, lo_q};

    always_comb begin
        state_d    = state_q;
        lo_d       = lo_q;
        rem_d      = rem_q;
        word_cnt_d = word_cnt_q;
        busy_d     = busy_q;
        err_d      = err_q;
        mem_we     = 1'b0;
        mem_wa     = word_cnt_q[MEM_AW-1:0];
`ifdef FRAME_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        if (state_q == DONE) begin
            state_d = IDLE;
            busy_d  = 1'b0;
        end else if (accept) begin
            case (state_q)
                IDLE: begin
                    lo_d       = rx_data;
                    busy_d     = 1'b1;
                    err_d      = 1'b0;
                    word_cnt_d = '0;
`ifdef FRAME_CHECKSUM_EN
                    csum_d     = '0;
`endif
                    state_d    = LEN_HI;
                end
                LEN_HI: begin
                    rem_d = rx_word;
                    if (rx_word > DEPTH_N) begin
                        err_d = 1'b1;
                    end
                    state_d = (rx_word == 16'd0) ? END_ST : DATA_LO;
                end
                DATA_LO: begin
                    lo_d    = rx_data;
                    state_d = DATA_HI;
                end
                DATA_HI: begin
                    // Oversize words are still consumed but never wrap to address 0.
                    if (word_cnt_q < DEPTH_C) begin
                        mem_we     = 1'b1;
                        word_cnt_d = word_cnt_q + 11'd1;
                    end
`ifdef FRAME_CHECKSUM_EN
                    csum_d  = csum_q + rx_word;
`endif
                    rem_d   = rem_q - 16'd1;
                    state_d = (rem_q == 16'd1) ? END_ST : DATA_LO;
                end
`ifdef FRAME_CHECKSUM_EN
                CS_LO: begin
                    lo_d    = rx_data;
                    state_d = CS_HI;
                end
                CS_HI: begin
                    if (rx_word != csum_q) begin
                        err_d = 1'b1;
                    end
                    state_d = DONE;
                end
`endif
                default: state_d = IDLE;
            endcase
        end
        // DONE lasts exactly one cycle, so the strobe mirrors entry into it.
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            lo_q         <= '0;
            rem_q        <= '0;
            word_cnt_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            data_input_q <= '0;
`ifdef FRAME_CHECKSUM_EN
            csum_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            lo_q         <= lo_d;
            rem_q        <= rem_d;
            word_cnt_q   <= word_cnt_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            // Read-before-write: the same-cycle write lands after this sample.
            data_input_q <= (input_addr < DEPTH_A) ? mem[input_addr[MEM_AW-1:0]] : '0;
`ifdef FRAME_CHECKSUM_EN
            csum_q       <= csum_d;
`endif
        end
    end

    // RAM contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_wa] <= rx_word;
        end
    end

    assign data_input = data_input_q;
    assign load_busy  = busy_q;
    assign load_done  = done_q;
    assign load_err   = err_q;
    assign word_cnt   = word_cnt_q;

endmodule

// File: tb/tb_frame_mem_loader.sv
module tb_frame_mem_loader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [19:0] input_addr = 20'h0;
    logic [15:0] data_input;
    logic        load_busy, load_done, load_err;
    logic [10:0] word_cnt;

`ifdef FRAME_CHECKSUM_EN
    localparam bit CS_EN = 1'b1;
`else
    localparam bit CS_EN = 1'b0;
`endif

    frame_mem_loader dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .input_addr(input_addr), .data_input(data_input), .load_busy(load_busy),
        .load_done(load_done), .load_err(load_err), .word_cnt(word_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: a load is a byte sequence indexed by position.
    // pos 0/1 = length, then 2N data bytes, then optional 2 trailer bytes.
    logic [15:0] m_mem [1024];
    bit          m_known [1024];
    logic [15:0] m_dout = 16'h0;
    bit          m_dout_known = 1'b0;
    bit          m_busy, m_done, m_err, m_indone;
    int          m_cnt, m_pos, m_n;
    logic [7:0]  m_lo;
    logic [15:0] m_sum;
    bit          started = 1'b0;
    int          done_pulses = 0;
    int          ready_low = 0;
    int          gap_pct = 30;
    logic [15:0] words[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        int total;
        logic [15:0] w;
        if (m_pos == 0) begin
            m_lo = b; m_busy = 1'b1; m_err = 1'b0; m_cnt = 0; m_sum = 16'h0;
        end else if (m_pos == 1) begin
            m_n = int'({b, m_lo});
            if (m_n > 1024) m_err = 1'b1;
        end else if (m_pos < 2 + 2 * m_n) begin
            if (m_pos % 2 == 0) begin
                m_lo = b;
            end else begin
                w = {b, m_lo};
                m_sum += w;
                if (m_cnt < 1024) begin
                    m_mem[m_cnt] = w;
                    m_known[m_cnt] = 1'b1;
                    m_cnt++;
                end
            end
        end else if (m_pos == 2 + 2 * m_n) begin
            m_lo = b;
        end else if ({b, m_lo} != m_sum) begin
            m_err = 1'b1;
        end
        m_pos++;
        total = 2 + 2 * m_n + (CS_EN ? 2 : 0);
        if (m_pos >= 2 && m_pos == total) begin
            m_indone = 1'b1;
            m_done = 1'b1;
        end
    endtask

    // Model and event counters advance on the same edge the DUT samples.
    always @(posedge clk) begin
        started = 1'b1;
        if (load_done === 1'b1) done_pulses++;
        if (rx_valid && rx_ready === 1'b0) ready_low++;
        if (rst) begin
            m_pos = 0; m_busy = 0; m_done = 0; m_err = 0; m_cnt = 0;
            m_dout = 16'h0; m_dout_known = 1'b1; m_indone = 0;
        end else begin
            if (input_addr < 20'd1024) begin
                m_dout = m_mem[input_addr[9:0]];
                m_dout_known = m_known[input_addr[9:0]];
            end else begin
                m_dout = 16'h0;
                m_dout_known = 1'b1;
            end
            if (m_indone) begin
                m_indone = 0; m_done = 0; m_busy = 0; m_pos = 0;
            end else if (rx_valid) begin
                model_byte(rx_data);
            end
        end
    end

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
        if (started) begin
            chk("rx_ready", {31'd0, rx_ready}, {31'd0, !m_indone});
            chk("load_busy", {31'd0, load_busy}, {31'd0, m_busy});
            chk("load_done", {31'd0, load_done}, {31'd0, m_done});
            chk("load_err", {31'd0, load_err}, {31'd0, m_err});
            chk("word_cnt", {21'd0, word_cnt}, 32'(m_cnt));
            if (m_dout_known) chk("data_input", {16'd0, data_input}, {16'd0, m_dout});
        end
    end

    function automatic logic [19:0] rand_addr();
        if ($urandom_range(9) == 0) return 20'($urandom);
        return 20'($urandom_range(1100));
    endfunction

    task automatic send_byte(input logic [7:0] b);
        int guard;
        while ($urandom_range(99) < gap_pct) begin
            rx_valid = 1'b0;
            input_addr = rand_addr();
            @(negedge clk);
        end
        rx_data = b;
        rx_valid = 1'b1;
        input_addr = rand_addr();
        guard = 0;
        while (rx_ready !== 1'b1 && guard < 8) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 8) begin
            checks++;
            errors++;
            $display("FAIL rx_ready_timeout got %0b want 1", rx_ready);
        end
        @(negedge clk);
    endtask

    task automatic send_load(input bit cs_bad);
        logic [15:0] n16;
        logic [15:0] sum;
        n16 = 16'(words.size());
        sum = 16'h0;
        send_byte(n16[7:0]);
        send_byte(n16[15:8]);
        foreach (words[i]) begin
            send_byte(words[i][7:0]);
            send_byte(words[i][15:8]);
            sum += words[i];
        end
        if (CS_EN) begin
            sum += 16'(cs_bad);
            send_byte(sum[7:0]);
            send_byte(sum[15:8]);
        end
    endtask

    task automatic idle(input int k);
        rx_valid = 1'b0;
        repeat (k) @(negedge clk);
    endtask

    task automatic read_chk(input string nm, input logic [19:0] a, input logic [15:0] exp);
        rx_valid = 1'b0;
        input_addr = a;
        @(negedge clk);
        chk(nm, {16'd0, data_input}, {16'd0, exp});
    endtask

    initial begin
        int dp;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, rx_ready}, 32'd1);
        chk("rst_busy", {31'd0, load_busy}, 32'd0);
        chk("rst_cnt", {21'd0, word_cnt}, 32'd0);
        chk("rst_dout", {16'd0, data_input}, 32'd0);
        rst = 1'b0;

        // Basic three-word load.
        dp = done_pulses;
        words = '{16'h1234, 16'h5678, 16'h9ABC};
        send_load(1'b0);
        idle(3);
        chk("t1_cnt", {21'd0, word_cnt}, 32'd3);
        chk("t1_done", 32'(done_pulses - dp), 32'd1);
        chk("t1_err", {31'd0, load_err}, 32'd0);
        chk("t1_model_mem0", {16'd0, m_mem[0]}, 32'h1234);
        read_chk("t2_addr1", 20'h00001, 16'h5678);
        read_chk("t2_addr2", 20'h00002, 16'h9ABC);
        read_chk("t2_addr400", 20'h00400, 16'h0000);

        // Oversize load: 1025 words, last one must not wrap to address 0.
        gap_pct = 0;
        words.delete();
        for (int i = 0; i < 1025; i++) words.push_back(16'(i) ^ 16'hA5A5);
        send_load(1'b0);
        idle(3);
        chk("t3_err", {31'd0, load_err}, 32'd1);
        chk("t3_cnt", {21'd0, word_cnt}, 32'd1024);
        chk("t3_model_cnt", 32'(m_cnt), 32'd1024);
        chk("t3_busy", {31'd0, load_busy}, 32'd0);
        read_chk("t3_addr0", 20'h00000, 16'hA5A5);
        read_chk("t3_addr3ff", 20'h003FF, 16'hA65A);

        // Reset in the middle of a 4-word load.
        gap_pct = 20;
        dp = done_pulses;
        send_byte(8'h04); send_byte(8'h00);
        send_byte(8'hDE); send_byte(8'hC0);
        send_byte(8'hEF); send_byte(8'hBE);
        send_byte(8'h01);
        rst = 1'b1;
        rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("t4_cnt", {21'd0, word_cnt}, 32'd0);
        chk("t4_busy", {31'd0, load_busy}, 32'd0);
        chk("t4_nodone", 32'(done_pulses - dp), 32'd0);
        read_chk("t4_addr0", 20'h00000, 16'hC0DE);
        read_chk("t4_addr1", 20'h00001, 16'hBEEF);
        read_chk("t4_addr2", 20'h00002, 16'hA5A7);
        words = '{16'h5555, 16'h6666, 16'h7777};
        send_load(1'b0);
        idle(3);
        chk("t4_next_done", 32'(done_pulses - dp), 32'd1);
        chk("t4_next_cnt", {21'd0, word_cnt}, 32'd3);
        read_chk("t4_next_addr2", 20'h00002, 16'h7777);

        // Back-to-back loads with rx_valid held high, ending with N=0.
        gap_pct = 0;
        ready_low = 0;
        dp = done_pulses;
        words = '{16'h1111, 16'h2222, 16'h3333};
        send_load(1'b0);
        words = '{16'hAAAA, 16'hBBBB};
        send_load(1'b0);
        words.delete();
        send_load(1'b0);
        idle(3);
        chk("t5_ready_low", 32'(ready_low), 32'd2);
        chk("t5_done", 32'(done_pulses - dp), 32'd3);
        chk("t5_cnt_n0", {21'd0, word_cnt}, 32'd0);
        read_chk("t5_addr0", 20'h00000, 16'hAAAA);
        read_chk("t5_addr1", 20'h00001, 16'hBBBB);
        read_chk("t5_addr2", 20'h00002, 16'h3333);

`ifdef FRAME_CHECKSUM_EN
        dp = done_pulses;
        words = '{16'h0001, 16'h0002};
        send_load(1'b0);
        idle(3);
        chk("t6_err_ok", {31'd0, load_err}, 32'd0);
        send_load(1'b1);
        idle(3);
        chk("t6_err_bad", {31'd0, load_err}, 32'd1);
        chk("t6_done", 32'(done_pulses - dp), 32'd2);
        read_chk("t6_addr1", 20'h00001, 16'h0002);
`endif

        // Randomized loads checked by the model every cycle.
        gap_pct = 30;
        for (int k = 0; k < 8; k++) begin
            int n;
            n = $urandom_range(0, 40);
            words.delete();
            for (int i = 0; i < n; i++) words.push_back(16'($urandom));
            send_load(1'($urandom_range(1)));
            idle($urandom_range(0, 3));
        end
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog got timeout want finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
